rv_mc_controller: RTL and testbench

- Parametrised next-generation control unit for the multicycle RV32I core.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives all datapath selects and enables.
- Adds four capabilities:
  - variable-latency memory handshake (mem_req/mem_ready) with an optional timeout;
  - full conditional-branch set;
  - LUI;
  - illegal-instruction/timeout trap with a halt.

---
 rtl/rv_mc_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_rv_mc_controller.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_controller.sv
// Multicycle RV32I control FSM with handshaked memory, full branch set,
// LUI, and an illegal-instruction / memory-timeout trap that halts.
//
// Ports:
//   clk, reset (async, active low)
//   op, funct3, funct7b5        instruction fields
//   zero, lt, ltu               ALU compare flags
//   mem_ready / mem_req         memory handshake
//   mem_write, adr_src, ir_write, pc_write, reg_write
//   imm_src, alu_src_a, alu_src_b, result_src, alu_control
//   trap, trap_cause            halt status

module rv_mc_controller #(
    parameter bit BRANCH_FULL = 1'b1,
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // Trap fires in the wait cycle whose increment would reach MEM_TIMEOUT.
    localparam bit TO_EN = (MEM_TIMEOUT > 0);
    localparam int TL    = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LIM = TL[TO_W-1:0];

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH,
        S_JAL, S_LUI, S_TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [2:0] imm_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic       trap;
    } ctl_t;

    state_t          state, nxt;
    logic [TO_W-1:0] cnt;
    logic [1:0]      cause_q, cause_n;
    ctl_t            c;
    logic            waiting, timeout;
    logic            br_ok, br_take;
    logic [2:0]      alu_op;

    assign waiting = (state inside {S_FETCH, S_MEMREAD, S_MEMWRITE})
                     && !mem_ready;
    assign timeout = TO_EN && waiting && (cnt >= TO_LIM);

    always_comb begin
        br_ok   = 1'b0;
        br_take = 1'b0;
        unique case (funct3)
            3'b000: begin br_ok = 1'b1;        br_take = zero; end
            3'b001: begin br_ok = BRANCH_FULL; br_take = !zero; end
            3'b100: begin br_ok = BRANCH_FULL; br_take = lt; end
            3'b101: begin br_ok = BRANCH_FULL; br_take = !lt; end
            3'b110: begin br_ok = BRANCH_FULL; br_take = ltu; end
            3'b111: begin br_ok = BRANCH_FULL; br_take = !ltu; end
            default: begin br_ok = 1'b0;       br_take = 1'b0; end
        endcase
    end

    always_comb begin
        alu_op = 3'b000;
        unique case (funct3)
            3'b000:  alu_op = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_op = 3'b101;
            3'b110:  alu_op = 3'b011;
            3'b111:  alu_op = 3'b010;
            default: alu_op = 3'b000;
        endcase
    end

    always_comb begin
        c       = '0;
        nxt     = state;
        cause_n = 2'b00;
        unique case (state)
            S_FETCH: begin
                c.mem_req = 1'b1;
                if (mem_ready) begin
                    c.ir_write   = 1'b1;
                    c.pc_write   = 1'b1;
                    c.alu_src_b  = 2'b10;
                    c.result_src = 2'b10;
                    nxt          = S_DECODE;
                end else if (timeout) begin
                    nxt     = S_TRAP;
                    cause_n = 2'b10;
                end
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 3'b010;
                unique case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R:              nxt = S_EXECR;
                    OP_I:              nxt = S_EXECI;
                    OP_B:              nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_LUI:            nxt = S_LUI;
                    default: begin
                        nxt     = S_TRAP;
                        cause_n = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
                nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
                if (mem_ready) begin
                    nxt = S_MEMWB;
                end else if (timeout) begin
                    nxt     = S_TRAP;
                    cause_n = 2'b10;
                end
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                nxt          = S_FETCH;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
                if (mem_ready) begin
                    nxt = S_FETCH;
                end else if (timeout) begin
                    nxt     = S_TRAP;
                    cause_n = 2'b10;
                end
            end
            S_EXECR: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = alu_op;
                nxt           = S_ALUWB;
            end
            S_EXECI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.alu_control = alu_op;
                nxt           = S_ALUWB;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                nxt         = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = 3'b001;
                c.pc_write    = br_ok && br_take;
                if (br_ok) begin
                    nxt = S_FETCH;
                end else begin
                    nxt     = S_TRAP;
                    cause_n = 2'b01;
                end
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
                nxt         = S_ALUWB;
            end
            S_LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
                c.imm_src   = 3'b100;
                nxt         = S_ALUWB;
            end
            S_TRAP: begin
                c.trap = 1'b1;
            end
            default: begin
                nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            cnt     <= '0;
            cause_q <= 2'b00;
        end else begin
            state <= nxt;
            // Any state change clears the counter, so each access starts at 0.
            if (nxt != state) begin
                cnt <= '0;
            end else if (waiting && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (nxt == S_TRAP && state != S_TRAP) begin
                cause_q <= cause_n;
            end
        end
    end

    // Gating by reset forces every output low while reset is held,
    // including mem_req in the middle of an access.
    assign {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            imm_src, alu_src_a, alu_src_b, result_src, alu_control,
            trap} = reset ? c : '0;
    assign trap_cause = reset ? cause_q : 2'b00;

endmodule

// File: tb/tb_rv_mc_controller.sv
// Self-checking bench for rv_mc_controller: instruction-level reference
// model producing per-cycle expected control vectors for two configs.

module tb_rv_mc_controller;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [2:0] imm;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] rs;
        logic [2:0] aluc;
        logic       trap;
        logic [1:0] cause;
    } ctl_t;

    typedef struct {
        logic       rdy;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       l;
        logic       lu;
        ctl_t       e;
        string      tag;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b0;

    logic       a_mem_req, a_mem_write, a_adr_src, a_ir_write;
    logic       a_pc_write, a_reg_write, a_trap;
    logic [2:0] a_imm_src, a_alu_control;
    logic [1:0] a_alu_src_a, a_alu_src_b, a_result_src, a_trap_cause;
    logic       b_mem_req, b_mem_write, b_adr_src, b_ir_write;
    logic       b_pc_write, b_reg_write, b_trap;
    logic [2:0] b_imm_src, b_alu_control;
    logic [1:0] b_alu_src_a, b_alu_src_b, b_result_src, b_trap_cause;

    ctl_t obs_a, obs_b;
    assign obs_a = {a_mem_req, a_mem_write, a_adr_src, a_ir_write,
                    a_pc_write, a_reg_write, a_imm_src, a_alu_src_a,
                    a_alu_src_b, a_result_src, a_alu_control, a_trap,
                    a_trap_cause};
    assign obs_b = {b_mem_req, b_mem_write, b_adr_src, b_ir_write,
                    b_pc_write, b_reg_write, b_imm_src, b_alu_src_a,
                    b_alu_src_b, b_result_src, b_alu_control, b_trap,
                    b_trap_cause};

    rv_mc_controller #(.BRANCH_FULL(1'b1), .MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .mem_req(a_mem_req),
        .mem_write(a_mem_write), .adr_src(a_adr_src),
        .ir_write(a_ir_write), .pc_write(a_pc_write),
        .reg_write(a_reg_write), .imm_src(a_imm_src),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .result_src(a_result_src), .alu_control(a_alu_control),
        .trap(a_trap), .trap_cause(a_trap_cause)
    );

    rv_mc_controller #(.BRANCH_FULL(1'b0), .MEM_TIMEOUT(0), .TO_W(8)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .mem_req(b_mem_req),
        .mem_write(b_mem_write), .adr_src(b_adr_src),
        .ir_write(b_ir_write), .pc_write(b_pc_write),
        .reg_write(b_reg_write), .imm_src(b_imm_src),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .result_src(b_result_src), .alu_control(b_alu_control),
        .trap(b_trap), .trap_cause(b_trap_cause)
    );

    always #5 clk = ~clk;

    int    nchk = 0;
    int    nerr = 0;
    step_t q[$];
    ctl_t  got_a[$];
    ctl_t  got_b[$];

    logic [6:0] m_op;
    logic [2:0] m_f3;
    logic       m_f7, m_z, m_l, m_lu;

    function automatic void push(logic r, ctl_t e, string t);
        step_t s;
        s.rdy = r;
        s.op = m_op; s.f3 = m_f3; s.f7 = m_f7;
        s.z = m_z; s.l = m_l; s.lu = m_lu;
        s.e = e;
        s.tag = t;
        q.push_back(s);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push_trap(logic [1:0] cause);
        ctl_t e = '0;
        e.trap = 1'b1;
        e.cause = cause;
        for (int i = 0; i < 3; i++) push(rnd(), e, "trap");
    endfunction

    // Memory access: n stall cycles then a ready cycle, unless the stall
    // count reaches the timeout, in which case the access ends in a trap.
    function automatic bit mem_phase(ctl_t base, ctl_t fin, int n,
                                     int tmo, string t);
        if (tmo > 0 && n >= tmo) begin
            for (int i = 0; i < tmo; i++) push(1'b0, base, t);
            push_trap(2'b10);
            return 1'b1;
        end
        for (int i = 0; i < n; i++) push(1'b0, base, t);
        push(1'b1, fin, t);
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f3,
                                          logic f7);
        if (f3 == 3'b000) return (o == OP_R && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Appends the expected cycles of one instruction; returns 1 on a trap.
    function automatic bit build(logic [6:0] o, logic [2:0] f3, logic f7,
                                 logic z, logic l, logic lu, int wf,
                                 int wm, bit full, int tmo);
        ctl_t e, f;
        bit   legal, take;
        m_op = o; m_f3 = f3; m_f7 = f7; m_z = z; m_l = l; m_lu = lu;
        e = '0;
        e.mem_req = 1'b1;
        f = e;
        f.ir_write = 1'b1;
        f.pc_write = 1'b1;
        f.asb = 2'b10;
        f.rs = 2'b10;
        if (mem_phase(e, f, wf, tmo, "fetch")) return 1'b1;
        e = '0;
        e.asa = 2'b01; e.asb = 2'b01; e.imm = 3'b010;
        push(rnd(), e, "decode");
        e = '0;
        if (o == OP_LOAD || o == OP_STORE) begin
            e.asa = 2'b10; e.asb = 2'b01;
            e.imm = (o == OP_STORE) ? 3'b001 : 3'b000;
            push(rnd(), e, "memadr");
            e = '0;
            e.mem_req = 1'b1; e.adr_src = 1'b1;
            e.mem_write = (o == OP_STORE);
            if (mem_phase(e, e, wm, tmo, "memacc")) return 1'b1;
            if (o == OP_LOAD) begin
                e = '0;
                e.rs = 2'b01; e.reg_write = 1'b1;
                push(rnd(), e, "memwb");
            end
            return 1'b0;
        end
        if (o == OP_B) begin
            legal = (f3 != 3'b010 && f3 != 3'b011) && (full || f3 == 3'b000);
            case (f3)
                3'b000:  take = z;
                3'b001:  take = !z;
                3'b100:  take = l;
                3'b101:  take = !l;
                3'b110:  take = lu;
                default: take = !lu;
            endcase
            e.asa = 2'b10; e.aluc = 3'b001;
            e.pc_write = legal && take;
            push(rnd(), e, "branch");
            if (!legal) begin
                push_trap(2'b01);
                return 1'b1;
            end
            return 1'b0;
        end
        if (o == OP_R) begin
            e.asa = 2'b10; e.aluc = alu_of(o, f3, f7);
            push(rnd(), e, "execr");
        end else if (o == OP_I) begin
            e.asa = 2'b10; e.asb = 2'b01; e.aluc = alu_of(o, f3, f7);
            push(rnd(), e, "execi");
        end else if (o == OP_JAL) begin
            e.asa = 2'b01; e.asb = 2'b10; e.pc_write = 1'b1;
            push(rnd(), e, "jal");
        end else if (o == OP_LUI) begin
            e.asa = 2'b11; e.asb = 2'b01; e.imm = 3'b100;
            push(rnd(), e, "lui");
        end else begin
            push_trap(2'b01);
            return 1'b1;
        end
        e = '0;
        e.reg_write = 1'b1;
        push(rnd(), e, "aluwb");
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic play();
        got_a.delete();
        got_b.delete();
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            op = q[i].op; funct3 = q[i].f3; funct7b5 = q[i].f7;
            zero = q[i].z; lt = q[i].l; ltu = q[i].lu;
            @(negedge clk);
            got_a.push_back(obs_a);
            got_b.push_back(obs_b);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op = OP_STORE;
        mem_ready = 1'b1;
        #3;
        nchk++;
        if (obs_a !== '0) begin
            nerr++;
            $display("FAIL reset_a got=%h exp=%h", obs_a, ctl_t'(0));
        end
        @(posedge clk);
        @(negedge clk);
        nchk++;
        if (obs_b !== '0) begin
            nerr++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, ctl_t'(0));
        end
    endtask

    task automatic test_alu();
        do_reset();
        q.delete();
        void'(build(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        void'(build(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        void'(build(OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 4));
        void'(build(OP_R, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        void'(build(OP_I, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 4));
        void'(build(OP_R, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        void'(build(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        void'(build(OP_LUI, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_a[i] !== q[i].e) begin
                nerr++;
                $display("FAIL alu %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_a[i], q[i].e);
            end
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        q.delete();
        void'(build(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b1, 4));
        void'(build(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 4));
        void'(build(OP_LOAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 4));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_a[i] !== q[i].e) begin
                nerr++;
                $display("FAIL memwait %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_a[i], q[i].e);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        q.delete();
        void'(build(OP_B, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        void'(build(OP_B, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 4));
        for (int k = 0; k < 12; k++) begin
            logic [2:0] f;
            f = (k % 2 == 0) ? 3'b100 : 3'b000;
            f = f | 3'(k % 4 == 1 ? 3'b001 : 3'b000);
            f = 3'($urandom_range(4, 7));
            if (k < 2) f = 3'(k);
            void'(build(OP_B, f, 1'b0, rnd(), rnd(), rnd(), 0, 0, 1'b1, 4));
        end
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_a[i] !== q[i].e) begin
                nerr++;
                $display("FAIL branch %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_a[i], q[i].e);
            end
        end
    endtask

    task automatic test_branch_lite();
        do_reset();
        q.delete();
        void'(build(OP_B, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0));
        void'(build(OP_B, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 0));
        void'(build(OP_B, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_b[i] !== q[i].e) begin
                nerr++;
                $display("FAIL blite %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_b[i], q[i].e);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        q.delete();
        void'(build(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0, 1'b1, 4));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_a[i] !== q[i].e) begin
                nerr++;
                $display("FAIL tmo_fetch %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_a[i], q[i].e);
            end
        end
        do_reset();
        q.delete();
        void'(build(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 4));
        void'(build(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1'b1, 4));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_a[i] !== q[i].e) begin
                nerr++;
                $display("FAIL tmo_edge %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_a[i], q[i].e);
            end
        end
        do_reset();
        q.delete();
        void'(build(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 20, 9, 1'b0, 0));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_b[i] !== q[i].e) begin
                nerr++;
                $display("FAIL tmo_off %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_b[i], q[i].e);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        q.delete();
        void'(build(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 4));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_a[i] !== q[i].e) begin
                nerr++;
                $display("FAIL illegal %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_a[i], q[i].e);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        op = OP_STORE;
        funct3 = 3'b010;
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        nchk++;
        if ({a_mem_req, a_mem_write, a_adr_src} !== 3'b111) begin
            nerr++;
            $display("FAIL midst_memwrite got=%b exp=111",
                     {a_mem_req, a_mem_write, a_adr_src});
        end
        reset = 1'b0;
        #1;
        nchk++;
        if (obs_a !== '0 || obs_b !== '0) begin
            nerr++;
            $display("FAIL midst_reset got=%h/%h exp=0", obs_a, obs_b);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        q.delete();
        void'(build(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 4));
        play();
        foreach (q[i]) begin
            nchk++;
            if (got_a[i] !== q[i].e) begin
                nerr++;
                $display("FAIL midst_after %s[%0d] got=%h exp=%h",
                         q[i].tag, i, got_a[i], q[i].e);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        bit tr;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_B, OP_JAL, OP_LUI,
                7'b0001111};
        do_reset();
        for (int n = 0; n < 80; n++) begin
            q.delete();
            tr = build(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                       rnd(), rnd(), rnd(), rnd(),
                       int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 5)), 1'b1, 4);
            play();
            foreach (q[i]) begin
                nchk++;
                if (got_a[i] !== q[i].e) begin
                    nerr++;
                    $display("FAIL rand%0d %s[%0d] got=%h exp=%h",
                             n, q[i].tag, i, got_a[i], q[i].e);
                end
            end
            if (tr) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_branch_lite();
        test_timeout();
        test_illegal();
        test_reset_mid_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
